// File: rtl/ldpc_pkg.sv
// Shared constants, record type and sign-magnitude helpers for the LDPC check-to-variable path.
// The optional offset-min-sum correction is enabled with LDPC_C2V_OFFSET_EN.
package ldpc_pkg;

   localparam int LLR_WIDTH  = 8;
   localparam int ROW_WEIGHT = 24;
   localparam int ROW_NUM    = 4;
   localparam int IDX_WIDTH  = 5;
   localparam int FIFO_DEPTH = 2;
   localparam int OFFSET     = 1;
   localparam int MAG_WIDTH  = LLR_WIDTH - 1;
   localparam int ROW_BITS   = $clog2(ROW_NUM);

   typedef logic [MAG_WIDTH-1:0] mag_t;

   typedef struct packed {
      mag_t                  min;
      mag_t                  submin;
      logic [IDX_WIDTH-1:0]  min_idx;
      logic [ROW_WEIGHT-1:0] signs;
   } c2v_rec_t;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } c2v_state_t;

   function automatic logic [LLR_WIDTH-1:0] sm_pack(input logic sign, input mag_t mag);
      return {sign, mag};
   endfunction

   function automatic logic sm_sign(input logic [LLR_WIDTH-1:0] llr);
      return llr[LLR_WIDTH-1];
   endfunction

   function automatic mag_t sm_mag(input logic [LLR_WIDTH-1:0] llr);
      return llr[LLR_WIDTH-2:0];
   endfunction

endpackage

// File: rtl/ldpc_c2v_fifo.sv
// Small record buffer between the check node unit and the serial c2v generator.
// Depth must be a power of two so the pointers wrap naturally.
module ldpc_c2v_fifo
   import ldpc_pkg::*;
#(
   parameter int DEPTH = FIFO_DEPTH
) (
   input  logic     clk,
   input  logic     rst_n,
   input  logic     push,
   input  c2v_rec_t push_data,
   input  logic     pop,
   output c2v_rec_t pop_data,
   output logic     full,
   output logic     empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count;
   c2v_rec_t         mem [DEPTH];
   logic             do_push;
   logic             do_pop;

   assign do_push  = push && !full;
   assign do_pop   = pop && !empty;
   assign full     = (count == CNT_W'(DEPTH));
   assign empty    = (count == '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: a slot is only read after it has been written.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/ldpc_c2v_gen.sv
// Expands compressed check-row records into ROW_WEIGHT serial check-to-variable LLRs.
// Define LDPC_C2V_OFFSET_EN to apply offset-min-sum correction to each magnitude.
module ldpc_c2v_gen
   import ldpc_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [MAG_WIDTH-1:0]  in_min,
   input  logic [MAG_WIDTH-1:0]  in_submin,
   input  logic [IDX_WIDTH-1:0]  in_min_idx,
   input  logic [ROW_WEIGHT-1:0] in_signs,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LLR_WIDTH-1:0]  out_llr,
   output logic [IDX_WIDTH-1:0]  out_col,
   output logic [ROW_BITS-1:0]   out_row,
   output logic                  out_last
);

   c2v_state_t           state;
   c2v_state_t           state_next;
   c2v_rec_t             work;
   c2v_rec_t             push_rec;
   c2v_rec_t             fifo_head;
   logic [IDX_WIDTH-1:0] col;
   logic [IDX_WIDTH-1:0] col_next;
   logic [ROW_BITS-1:0]  row;
   logic [ROW_BITS-1:0]  row_next;
   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 fifo_pop;
   logic                 load;
   logic                 last_col;
   logic                 emitting;
   mag_t                 mag;
   mag_t                 mag_out;
   logic                 sign;
   logic                 sign_out;

   assign push_rec = '{min: in_min, submin: in_submin, min_idx: in_min_idx, signs: in_signs};
   assign in_ready = !fifo_full;

   ldpc_c2v_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (in_valid),
      .push_data (push_rec),
      .pop       (fifo_pop),
      .pop_data  (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign emitting = (state == EMIT);
   assign last_col = (col == IDX_WIDTH'(ROW_WEIGHT - 1));

   // On the final beat of a row the next record is fetched in the same cycle so rows abut.
   always_comb begin
      state_next = state;
      col_next   = col;
      row_next   = row;
      fifo_pop   = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               load       = 1'b1;
               col_next   = '0;
               state_next = EMIT;
            end
         end
         EMIT: begin
            if (out_ready) begin
               if (last_col) begin
                  col_next = '0;
                  row_next = (row == ROW_BITS'(ROW_NUM - 1)) ? '0 : row + 1'b1;
                  if (!fifo_empty) begin
                     fifo_pop = 1'b1;
                     load     = 1'b1;
                  end else begin
                     state_next = IDLE;
                  end
               end else begin
                  col_next = col + 1'b1;
               end
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         col   <= '0;
         row   <= '0;
         work  <= '0;
      end else begin
         state <= state_next;
         col   <= col_next;
         row   <= row_next;
         if (load) work <= fifo_head;
      end
   end

   // An out-of-range min_idx never matches a column, so every column then gets min.
   always_comb begin
      mag  = (col == work.min_idx) ? work.submin : work.min;
      sign = (^work.signs) ^ work.signs[col];
`ifdef LDPC_C2V_OFFSET_EN
      mag_out = (mag > MAG_WIDTH'(OFFSET)) ? mag - MAG_WIDTH'(OFFSET) : '0;
`else
      mag_out = mag;
`endif
      sign_out = (mag_out == '0) ? 1'b0 : sign;
   end

   assign out_valid = emitting;
   assign out_llr   = emitting ? sm_pack(sign_out, mag_out) : '0;
   assign out_col   = emitting ? col : '0;
   assign out_last  = emitting && last_col;
   assign out_row   = row;

endmodule

// File: tb/tb_ldpc_c2v_gen.sv
// Scoreboard bench for ldpc_c2v_gen: each accepted record queues its 24 expected beats.
// Honours LDPC_C2V_OFFSET_EN in the reference model.
module tb_ldpc_c2v_gen;
   import ldpc_pkg::*;

   typedef struct packed {
      logic [LLR_WIDTH-1:0] llr;
      logic [IDX_WIDTH-1:0] col;
      logic [ROW_BITS-1:0]  row;
      logic                 last;
   } beat_t;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  in_valid = 1'b0;
   logic                  in_ready;
   logic [MAG_WIDTH-1:0]  in_min = '0;
   logic [MAG_WIDTH-1:0]  in_submin = '0;
   logic [IDX_WIDTH-1:0]  in_min_idx = '0;
   logic [ROW_WEIGHT-1:0] in_signs = '0;
   logic                  out_valid;
   logic                  out_ready = 1'b1;
   logic [LLR_WIDTH-1:0]  out_llr;
   logic [IDX_WIDTH-1:0]  out_col;
   logic [ROW_BITS-1:0]   out_row;
   logic                  out_last;

   int    total = 0;
   int    bad = 0;
   beat_t sb[$];
   int    model_row = 0;

   ldpc_c2v_gen dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_min     (in_min),
      .in_submin  (in_submin),
      .in_min_idx (in_min_idx),
      .in_signs   (in_signs),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_llr    (out_llr),
      .out_col    (out_col),
      .out_row    (out_row),
      .out_last   (out_last)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Reference beat: sign is the parity of every other column's sign, computed by a loop.
   function automatic beat_t modelBeat(input mag_t mn, input mag_t smn, input logic [IDX_WIDTH-1:0] idx,
                                       input logic [ROW_WEIGHT-1:0] sg, input int j, input int r);
      beat_t b;
      int    m;
      logic  p;
      m = (j == int'(idx)) ? int'(smn) : int'(mn);
`ifdef LDPC_C2V_OFFSET_EN
      m = (m > OFFSET) ? m - OFFSET : 0;
`endif
      p = 1'b0;
      for (int k = 0; k < ROW_WEIGHT; k++) if (k != j) p = p ^ sg[k];
      if (m == 0) p = 1'b0;
      b.llr  = {p, MAG_WIDTH'(m)};
      b.col  = IDX_WIDTH'(j);
      b.row  = ROW_BITS'(r);
      b.last = (j == ROW_WEIGHT - 1);
      return b;
   endfunction

   task automatic applyStimulus(input mag_t mn, input mag_t smn, input logic [IDX_WIDTH-1:0] idx,
                                input logic [ROW_WEIGHT-1:0] sg, input bit toggle);
      bit acc;
      bit accepted;
      in_min     = mn;
      in_submin  = smn;
      in_min_idx = idx;
      in_signs   = sg;
      in_valid   = 1'b1;
      accepted   = 1'b0;
      for (int c = 0; c < 600 && !accepted; c++) begin
         acc = in_ready;
         @(posedge clk);
         if (acc) begin
            accepted = 1'b1;
            for (int j = 0; j < ROW_WEIGHT; j++) sb.push_back(modelBeat(mn, smn, idx, sg, j, model_row));
            model_row = (model_row == ROW_NUM - 1) ? 0 : model_row + 1;
         end
         #1;
         if (toggle) out_ready = ~out_ready;
      end
      in_valid = 1'b0;
      if (!accepted) checkOutput("accept_timeout", 0, 1);
   endtask

   task automatic waitDrain(input bit toggle);
      bit done;
      done = 1'b0;
      for (int c = 0; c < 3000 && !done; c++) begin
         if (sb.size() == 0 && !out_valid) done = 1'b1;
         else begin
            @(posedge clk);
            #1;
            if (toggle) out_ready = ~out_ready;
         end
      end
      if (!done) checkOutput("drain_timeout", 0, 1);
      out_ready = 1'b1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      #1;
      checkOutput("rst_in_ready", 32'(in_ready), 1);
      checkOutput("rst_out_valid", 32'(out_valid), 0);
      checkOutput("rst_out_llr", 32'(out_llr), 0);
      checkOutput("rst_out_col", 32'(out_col), 0);
      checkOutput("rst_out_row", 32'(out_row), 0);
      checkOutput("rst_out_last", 32'(out_last), 0);
      sb.delete();
      model_row = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Monitor: compares handshaken beats, output stability under stall, and no-bubble row changes.
   bit    stalled_prev = 1'b0;
   bit    expect_next = 1'b0;
   beat_t held;
   always @(negedge clk) begin
      beat_t e;
      if (!rst_n) begin
         stalled_prev = 1'b0;
         expect_next  = 1'b0;
      end else begin
         if (stalled_prev) begin
            checkOutput("stall_valid", 32'(out_valid), 1);
            checkOutput("stall_llr", 32'(out_llr), 32'(held.llr));
            checkOutput("stall_col", 32'(out_col), 32'(held.col));
            checkOutput("stall_last", 32'(out_last), 32'(held.last));
         end
         if (expect_next) begin
            checkOutput("no_bubble_valid", 32'(out_valid), 1);
            checkOutput("no_bubble_col", 32'(out_col), 0);
         end
         expect_next  = 1'b0;
         stalled_prev = out_valid && !out_ready;
         held         = '{llr: out_llr, col: out_col, row: out_row, last: out_last};
         if (out_valid && out_ready) begin
            if (sb.size() == 0) checkOutput("unexpected_beat", 1, 0);
            else begin
               e = sb.pop_front();
               checkOutput("beat_llr", 32'(out_llr), 32'(e.llr));
               checkOutput("beat_col", 32'(out_col), 32'(e.col));
               checkOutput("beat_row", 32'(out_row), 32'(e.row));
               checkOutput("beat_last", 32'(out_last), 32'(e.last));
               if (e.last && sb.size() > 0) expect_next = 1'b1;
            end
         end
      end
   end

   initial begin
      bit done;
      $display("[TB] start");
      doReset();

      // Single record, then check the T+2 latency.
      applyStimulus(7'd3, 7'd9, 5'd5, 24'h000000, 1'b0);
      checkOutput("latency_t1", 32'(out_valid), 0);
      @(posedge clk);
      #1;
      checkOutput("latency_t2", 32'(out_valid), 1);
      checkOutput("latency_col0", 32'(out_col), 0);
      waitDrain(1'b0);

      // Single negative column sign.
      applyStimulus(7'd3, 7'd9, 5'd5, 24'h000001, 1'b0);
      waitDrain(1'b0);

      // Five back-to-back records from a clean reset: rows 0,1,2,3,0.
      doReset();
      applyStimulus(7'd10, 7'd20, 5'd0, 24'h800001, 1'b0);
      applyStimulus(7'd1, 7'd2, 5'd23, 24'hA5A5A5, 1'b0);
      applyStimulus(7'd63, 7'd127, 5'd12, 24'hFFFFFF, 1'b0);
      applyStimulus(7'd5, 7'd6, 5'd7, 24'h123456, 1'b0);
      applyStimulus(7'd2, 7'd4, 5'd1, 24'h0F0F0F, 1'b0);
      waitDrain(1'b0);

      // Backpressure: fill the buffer while stalled, then toggle out_ready.
      out_ready = 1'b0;
      applyStimulus(7'd8, 7'd11, 5'd3, 24'h00F00F, 1'b0);
      applyStimulus(7'd9, 7'd12, 5'd4, 24'h0000F0, 1'b0);
      applyStimulus(7'd7, 7'd13, 5'd22, 24'h400000, 1'b0);
      checkOutput("in_ready_full", 32'(in_ready), 0);
      applyStimulus(7'd6, 7'd14, 5'd9, 24'h111111, 1'b1);
      waitDrain(1'b1);

      // Zero magnitude, out-of-range index, offset edge.
      applyStimulus(7'd0, 7'd5, 5'd2, 24'h0000F0, 1'b0);
      applyStimulus(7'd4, 7'd1, 5'd31, 24'h00ABCD, 1'b0);
      applyStimulus(7'd1, 7'd6, 5'd31, 24'hFF00FF, 1'b0);
      applyStimulus(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                    5'($urandom_range(0, 23)), 24'($urandom), 1'b0);
      waitDrain(1'b0);

      // Reset in the middle of a row.
      applyStimulus(7'd3, 7'd9, 5'd5, 24'h000003, 1'b0);
      done = 1'b0;
      for (int c = 0; c < 100 && !done; c++) begin
         @(posedge clk);
         #1;
         if (out_valid && out_col == 5'd10) done = 1'b1;
      end
      if (!done) checkOutput("col10_timeout", 0, 1);
      doReset();
      applyStimulus(7'd12, 7'd15, 5'd0, 24'h000010, 1'b0);
      waitDrain(1'b0);

      checkOutput("scoreboard_empty", 32'(sb.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
